// File: rtl/dekatron_counter_sequencer.sv
// rtl/dekatron_counter_sequencer.sv - two-requester command sequencer for a shared dekatron counter
module dekatron_counter_sequencer #(
  parameter int D_NUM          = 3,
  parameter int DEKATRON_WIDTH = 4,
  parameter int WIDTH          = D_NUM * DEKATRON_WIDTH,
  parameter int STEP_WIDTH     = 8,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic [1:0]            Op0,
  input  logic [1:0]            Op1,
  input  logic [STEP_WIDTH-1:0] Steps0,
  input  logic [STEP_WIDTH-1:0] Steps1,
  input  logic [WIDTH-1:0]      Data0,
  input  logic [WIDTH-1:0]      Data1,
  output logic                  Gnt0,
  output logic                  Gnt1,
  output logic                  Done0,
  output logic                  Done1,
  output logic [STEP_WIDTH-1:0] StepsDone,
  output logic                  Error,
  output logic                  Busy,
  output logic                  CntRequest,
  output logic                  CntDec,
  output logic                  CntSet,
  output logic [WIDTH-1:0]      CntIn,
  input  logic                  CntReady,
  input  logic                  CntZero
);

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_DTZ = 2'b11;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

  state_t                state;
  logic                  owner;
  logic                  rr_ptr;
  logic                  skip_q;
  logic [1:0]            op_q;
  logic [WIDTH-1:0]      data_q;
  logic [STEP_WIDTH-1:0] remaining;
  logic [SW-1:0]         settle_cnt;
  logic [TW-1:0]         wait_cnt;

  logic                  win;
  logic [1:0]            win_op;
  logic [STEP_WIDTH-1:0] win_steps;
  logic [WIDTH-1:0]      win_data;
  logic                  win_skip;

  // Round-robin pick between the requesters and whether the winner's command needs no steps
  always_comb begin
    win       = 1'b0;
    win_skip  = 1'b0;
    if (Req0 && Req1) begin
      win = rr_ptr;
    end else if (Req1) begin
      win = 1'b1;
    end
    win_op    = win ? Op1 : Op0;
    win_steps = win ? Steps1 : Steps0;
    win_data  = win ? Data1 : Data0;
    case (win_op)
      OP_INC, OP_DEC: win_skip = (win_steps == '0);
      OP_DTZ:         win_skip = (win_steps == '0) || CntZero;
      default:        win_skip = 1'b0;
    endcase
  end

  // Command FSM; the grant cycle is spent in IDLE with Gnt high, then steps are issued one at a time
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      skip_q     <= 1'b0;
      op_q       <= OP_INC;
      data_q     <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
      wait_cnt   <= '0;
      Gnt0       <= 1'b0;
      Gnt1       <= 1'b0;
      Done0      <= 1'b0;
      Done1      <= 1'b0;
      StepsDone  <= '0;
      Error      <= 1'b0;
      Busy       <= 1'b0;
      CntRequest <= 1'b0;
      CntDec     <= 1'b0;
      CntSet     <= 1'b0;
      CntIn      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Gnt0 || Gnt1) begin
            Gnt0 <= 1'b0;
            Gnt1 <= 1'b0;
            if (skip_q) begin
              state <= DONE;
              Done0 <= ~owner;
              Done1 <= owner;
            end else begin
              state      <= ISSUE;
              CntRequest <= 1'b1;
              CntDec     <= (op_q == OP_DEC) || (op_q == OP_DTZ);
              CntSet     <= (op_q == OP_SET);
              CntIn      <= data_q;
            end
          end else if ((Req0 || Req1) && CntReady) begin
            Gnt0      <= ~win;
            Gnt1      <= win;
            Busy      <= 1'b1;
            owner     <= win;
            op_q      <= win_op;
            data_q    <= win_data;
            skip_q    <= win_skip;
            remaining <= (win_op == OP_SET) ? STEP_WIDTH'(1) : win_steps;
            StepsDone <= '0;
            Error     <= 1'b0;
            if (Req0 && Req1) begin
              rr_ptr <= ~win;
            end
          end
        end
        ISSUE: begin
          CntRequest <= 1'b0;
          settle_cnt <= SETTLE_LAST;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        WAIT: begin
          if (CntReady) begin
            if (StepsDone != '1) begin
              StepsDone <= StepsDone + 1'b1;
            end
            remaining <= remaining - 1'b1;
            if ((remaining == STEP_WIDTH'(1)) || ((op_q == OP_DTZ) && CntZero)) begin
              state  <= DONE;
              Done0  <= ~owner;
              Done1  <= owner;
              CntDec <= 1'b0;
              CntSet <= 1'b0;
              CntIn  <= '0;
            end else begin
              state      <= ISSUE;
              CntRequest <= 1'b1;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            Error  <= 1'b1;
            state  <= DONE;
            Done0  <= ~owner;
            Done1  <= owner;
            CntDec <= 1'b0;
            CntSet <= 1'b0;
            CntIn  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          Done0 <= 1'b0;
          Done1 <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_counter_sequencer.sv
// tb/tb_dekatron_counter_sequencer.sv - directed bench with behavioural counter and command model
module tb_dekatron_counter_sequencer;

  localparam int WIDTH   = 12;
  localparam int STEPW   = 8;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1023;
  localparam int LAT     = 4;
  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_DTZ = 2'b11;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Req0 = 1'b0, Req1 = 1'b0;
  logic [1:0]       Op0 = '0, Op1 = '0;
  logic [STEPW-1:0] Steps0 = '0, Steps1 = '0;
  logic [WIDTH-1:0] Data0 = '0, Data1 = '0;
  logic             Gnt0, Gnt1, Done0, Done1, Error, Busy;
  logic             CntRequest, CntDec, CntSet;
  logic [STEPW-1:0] StepsDone;
  logic [WIDTH-1:0] CntIn;
  logic             CntReady = 1'b1;
  logic             CntZero = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  // monitor / model state
  int cyc = 0;
  int in_cmd = 0, owner = 0, ptr = 0, last_err = 0;
  int e_op = 0, e_data = 0, e_sd = 0, e_err = 0, e_nreq = 0;
  int nreq = 0, gnt_cyc = 0, last_req_cyc = 0, ready_cyc = 0;
  int gnt_cnt = 0, done_cnt = 0, last_gnt = 0, last_sd = 0, last_nreq = 0, last_done_err = 0;
  // counter model state
  int ctr_val = 0, req_total = 0, stall_at = -1;
  int c_busy = 0, c_left = 0, c_id = 0, c_dec = 0, c_set = 0, c_in = 0;

  always #5 Clk = ~Clk;

  dekatron_counter_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
    .Steps0(Steps0), .Steps1(Steps1), .Data0(Data0), .Data1(Data1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .StepsDone(StepsDone), .Error(Error), .Busy(Busy),
    .CntRequest(CntRequest), .CntDec(CntDec), .CntSet(CntSet), .CntIn(CntIn),
    .CntReady(CntReady), .CntZero(CntZero)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [WIDTH-1:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // compare process plus behavioural counter, both evaluated at the falling edge
  task automatic monitor();
    int g, ew, nominal, avail, steps;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst_n) begin
        in_cmd = 0;
        ptr = 0;
        last_err = 0;
      end else begin
        if (Gnt0 || Gnt1) begin
          chk("gnt_both", int'(Gnt0 && Gnt1), 0);
          chk("gnt_while_busy", in_cmd, 0);
          g = Gnt1 ? 1 : 0;
          if (Req0 && Req1) begin
            ew = ptr;
            ptr = 1 - ptr;
          end else begin
            ew = Req1 ? 1 : 0;
          end
          chk("gnt_owner", g, ew);
          chk("error_clear_at_gnt", int'(Error), 0);
          e_op   = g ? int'(Op1) : int'(Op0);
          steps  = g ? int'(Steps1) : int'(Steps0);
          e_data = g ? int'(Data1) : int'(Data0);
          if (e_op == 2) nominal = 1;
          else if (e_op == 3) nominal = imin(steps, ctr_val);
          else nominal = steps;
          avail = (stall_at >= 0) ? stall_at - req_total : 1000000;
          if (nominal > avail) begin
            e_sd = avail; e_err = 1; e_nreq = avail + 1;
          end else begin
            e_sd = nominal; e_err = 0; e_nreq = nominal;
          end
          in_cmd = 1; owner = g; nreq = 0; gnt_cyc = cyc;
          last_gnt = g; gnt_cnt++;
        end
        chk("busy", int'(Busy), in_cmd);
        if (CntRequest) begin
          chk("req_in_cmd", in_cmd, 1);
          nreq++;
          if (nreq == 1) chk("gnt_to_req", cyc - gnt_cyc, 1);
          chk("req_dec", int'(CntDec), int'(e_op == 1 || e_op == 3));
          chk("req_set", int'(CntSet), int'(e_op == 2));
          chk("req_in", int'(CntIn), e_data);
          last_req_cyc = cyc;
        end
        if (Done0 || Done1) begin
          chk("done_in_cmd", in_cmd, 1);
          chk("done_both", int'(Done0 && Done1), 0);
          chk("done_owner", int'(Done1), owner);
          chk("steps_done", int'(StepsDone), e_sd);
          chk("done_error", int'(Error), e_err);
          chk("req_count", nreq, e_nreq);
          if (e_nreq == 0) chk("gnt_to_done", cyc - gnt_cyc, 1);
          else if (e_err != 0) chk("timeout_latency", cyc - last_req_cyc, 1 + SETTLE + TIMEOUT);
          else chk("ready_to_done", cyc - ready_cyc, 1);
          chk("done_cnt_outputs", int'({CntRequest, CntDec, CntSet, CntIn}), 0);
          last_sd = int'(StepsDone); last_nreq = nreq; last_done_err = int'(Error);
          last_err = e_err; done_cnt++;
          in_cmd = 0;
        end else if (!in_cmd) begin
          chk("error_hold", int'(Error), last_err);
          chk("idle_cnt_outputs", int'({CntRequest, CntDec, CntSet, CntIn}), 0);
        end
      end
      if (c_busy != 0) begin
        if (c_id != stall_at) begin
          c_left--;
          if (c_left == 0) begin
            if (c_set != 0) ctr_val = bcd2int(c_in[WIDTH-1:0]);
            else if (c_dec != 0) ctr_val = (ctr_val + 999) % 1000;
            else ctr_val = (ctr_val + 1) % 1000;
            CntReady = 1'b1;
            c_busy = 0;
            ready_cyc = cyc;
          end
        end
      end else if (CntRequest) begin
        c_id = req_total; req_total++;
        c_busy = 1; c_left = LAT; CntReady = 1'b0;
        c_dec = int'(CntDec); c_set = int'(CntSet); c_in = int'(CntIn);
      end
      CntZero = (ctr_val == 0);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_gnt(input int base);
    for (int i = 0; i < 60 && gnt_cnt == base; i++) step();
    if (gnt_cnt == base) chk("gnt_wait_expired", 0, 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 1500 && done_cnt < target; i++) step();
    if (done_cnt < target) chk("done_wait_expired", done_cnt, target);
  endtask

  task automatic drive(input int who, input logic [1:0] op, input int steps, input logic [WIDTH-1:0] data);
    if (who == 0) begin
      Req0 = 1'b1; Op0 = op; Steps0 = STEPW'(steps); Data0 = data;
    end else begin
      Req1 = 1'b1; Op1 = op; Steps1 = STEPW'(steps); Data1 = data;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) Req0 = 1'b0;
    else Req1 = 1'b0;
  endtask

  task automatic run_cmd(input int who, input logic [1:0] op, input int steps, input logic [WIDTH-1:0] data);
    int g0, d0;
    g0 = gnt_cnt; d0 = done_cnt;
    drive(who, op, steps, data);
    wait_gnt(g0);
    drop(who);
    wait_done(d0 + 1);
    step();
  endtask

  task automatic both_episode(input int exp_first, input int exp_second, input string tag);
    int g0, d0;
    g0 = gnt_cnt; d0 = done_cnt;
    drive(0, OP_INC, 1, 12'h011);
    drive(1, OP_INC, 1, 12'h022);
    wait_gnt(g0);
    chk({tag, "_first"}, last_gnt, exp_first);
    drop(last_gnt);
    wait_gnt(g0 + 1);
    chk({tag, "_second"}, last_gnt, exp_second);
    drop(last_gnt);
    wait_done(d0 + 2);
    step();
  endtask

  initial begin
    int d0, g0;
    fork
      monitor();
    join_none
    repeat (3) step();
    chk("rst_gnt",   int'({Gnt0, Gnt1}), 0);
    chk("rst_done",  int'({Done0, Done1}), 0);
    chk("rst_busy",  int'(Busy), 0);
    chk("rst_error", int'(Error), 0);
    chk("rst_steps", int'(StepsDone), 0);
    chk("rst_cnt",   int'({CntRequest, CntDec, CntSet, CntIn}), 0);
    Rst_n = 1'b1;
    repeat (2) step();

    run_cmd(0, OP_INC, 3, 12'h0ab);
    chk("inc3_steps", last_sd, 3);
    chk("inc3_reqs", last_nreq, 3);
    chk("inc3_ctr", ctr_val, 3);

    both_episode(0, 1, "arb_a");
    both_episode(1, 0, "arb_b");
    chk("arb_ctr", ctr_val, 7);

    run_cmd(1, OP_SET, 7, 12'h123);
    chk("set_steps", last_sd, 1);
    chk("set_ctr", ctr_val, 123);

    run_cmd(0, OP_SET, 0, 12'h002);
    chk("set2_ctr", ctr_val, 2);
    run_cmd(0, OP_DTZ, 10, 12'h000);
    chk("dtz_steps", last_sd, 2);
    chk("dtz_ctr", ctr_val, 0);

    run_cmd(0, OP_INC, 0, 12'h005);
    chk("inc0_steps", last_sd, 0);
    chk("inc0_reqs", last_nreq, 0);
    run_cmd(1, OP_DTZ, 5, 12'h000);
    chk("dtz_zero_steps", last_sd, 0);
    chk("dtz_zero_reqs", last_nreq, 0);
    run_cmd(1, OP_DEC, 0, 12'h000);
    chk("dec0_reqs", last_nreq, 0);

    run_cmd(1, OP_INC, 5, 12'h050);
    run_cmd(0, OP_DEC, 2, 12'h020);
    chk("incdec_ctr", ctr_val, 3);

    stall_at = req_total + 1;
    run_cmd(0, OP_INC, 3, 12'h030);
    chk("to_steps", last_sd, 1);
    chk("to_error", last_done_err, 1);
    chk("to_reqs", last_nreq, 2);
    repeat (3) step();
    chk("to_error_held", int'(Error), 1);
    stall_at = -1;
    run_cmd(1, OP_INC, 1, 12'h001);
    chk("after_to_error", last_done_err, 0);
    chk("after_to_ctr", ctr_val, 6);

    stall_at = req_total;
    d0 = done_cnt; g0 = gnt_cnt;
    drive(0, OP_INC, 2, 12'h044);
    wait_gnt(g0);
    drop(0);
    repeat (10) step();
    chk("pre_rst_busy", int'(Busy), 1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  int'(Busy), 0);
    chk("mid_rst_done",  int'({Done0, Done1, Gnt0, Gnt1}), 0);
    chk("mid_rst_error", int'(Error), 0);
    chk("mid_rst_steps", int'(StepsDone), 0);
    chk("mid_rst_cnt",   int'({CntRequest, CntDec, CntSet, CntIn}), 0);
    repeat (3) step();
    Rst_n = 1'b1;
    stall_at = -1;
    repeat (20) step();
    chk("no_done_after_rst", done_cnt, d0);
    chk("rst_inflight_ctr", ctr_val, 7);
    run_cmd(0, OP_DEC, 1, 12'h001);
    chk("recover_ctr", ctr_val, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
